// File: rtl/countdown.sv
// countdown: minute:second countdown timer driven by a 1 Hz tick.
//
// A preset MM:SS value is loaded, then counted down once per sec_p tick,
// borrowing a minute when the seconds field passes zero. Reaching 00:00
// moves the timer to DONE, fires a one-cycle expire_p and raises alarm
// for ALARM_SEC further ticks (or until stop / load silences it).
//
// Parameters:
//   MAX_MIN    largest loadable minute value; larger presets are clamped
//   ALARM_SEC  number of sec_p ticks the alarm stays high (1..63)
//
// Ports:
//   mclk      in   system clock
//   reset     in   synchronous active-high reset
//   sec_p     in   one-cycle 1 Hz tick
//   load      in   capture load_min / load_sec (ignored while counting)
//   load_min  in   preset minutes (7 bits)
//   load_sec  in   preset seconds (6 bits)
//   start     in   begin / resume counting
//   stop      in   pause counting, or silence the alarm in DONE
//   r_min     out  current minutes
//   r_sec     out  current seconds
//   running   out  high while counting
//   expire_p  out  one-cycle pulse on reaching 00:00
//   alarm     out  alarm level
//   done      out  high while expired, until load or reset
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | preset held, waiting for start
// ST_RUN   | counting down on each sec_p
// ST_PAUSE | count frozen by stop, waiting for start
// ST_DONE  | reached 00:00; alarm timed by sec_p until it expires or stop

module countdown #(
  parameter int MAX_MIN   = 99,
  parameter int ALARM_SEC = 5
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       sec_p,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] r_min,
  output logic [5:0] r_sec,
  output logic       running,
  output logic       expire_p,
  output logic       alarm,
  output logic       done
);

  localparam logic [6:0] MIN_CAP    = 7'(MAX_MIN);
  localparam logic [5:0] SEC_CAP    = 6'd59;
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] min_nxt;
  logic [5:0] sec_nxt;
  logic       expire_nxt;
  logic       alarm_nxt;
  logic [5:0] alarm_cnt;
  logic [5:0] alarm_cnt_nxt;

  logic [6:0] min_clamp;
  logic [5:0] sec_clamp;
  logic       is_zero;

  always_comb begin
    min_clamp = (load_min > MIN_CAP) ? MIN_CAP : load_min;
    sec_clamp = (load_sec > SEC_CAP) ? SEC_CAP : load_sec;
    is_zero   = (r_min == 7'd0) && (r_sec == 6'd0);
  end

  always_comb begin
    state_nxt     = state;
    min_nxt       = r_min;
    sec_nxt       = r_sec;
    expire_nxt    = 1'b0;
    alarm_nxt     = alarm;
    alarm_cnt_nxt = alarm_cnt;

    case (state)
      ST_IDLE, ST_PAUSE: begin
        // stop has no effect here but still masks load/start that cycle
        if (!stop) begin
          if (load) begin
            min_nxt       = min_clamp;
            sec_nxt       = sec_clamp;
            state_nxt     = ST_IDLE;
            alarm_nxt     = 1'b0;
            alarm_cnt_nxt = 6'd0;
          end else if (start && !is_zero) begin
            state_nxt = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_PAUSE;
        end else if (sec_p) begin
          if (r_sec != 6'd0) begin
            sec_nxt = r_sec - 6'd1;
            // last second of the last minute: expire on this same edge
            if ((r_min == 7'd0) && (r_sec == 6'd1)) begin
              state_nxt     = ST_DONE;
              expire_nxt    = 1'b1;
              alarm_nxt     = 1'b1;
              alarm_cnt_nxt = 6'd0;
            end
          end else if (r_min != 7'd0) begin
            min_nxt = r_min - 7'd1;
            sec_nxt = SEC_CAP;
          end
        end
      end

      ST_DONE: begin
        if (stop) begin
          alarm_nxt = 1'b0;
        end else if (load) begin
          min_nxt       = min_clamp;
          sec_nxt       = sec_clamp;
          state_nxt     = ST_IDLE;
          alarm_nxt     = 1'b0;
          alarm_cnt_nxt = 6'd0;
        end else if (sec_p && alarm) begin
          alarm_cnt_nxt = alarm_cnt + 6'd1;
          if (alarm_cnt_nxt == ALARM_LAST) begin
            alarm_nxt = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      r_min     <= 7'd0;
      r_sec     <= 6'd0;
      running   <= 1'b0;
      expire_p  <= 1'b0;
      alarm     <= 1'b0;
      done      <= 1'b0;
      alarm_cnt <= 6'd0;
    end else begin
      state     <= state_nxt;
      r_min     <= min_nxt;
      r_sec     <= sec_nxt;
      running   <= (state_nxt == ST_RUN);
      expire_p  <= expire_nxt;
      alarm     <= alarm_nxt;
      done      <= (state_nxt == ST_DONE);
      alarm_cnt <= alarm_cnt_nxt;
    end
  end

endmodule
